// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller sitting on the multicycle CPU's memory port.
// Decodes each access to an external synchronous RAM (fixed read latency) or to
// one of three internal peripherals: LED register, switch input, down-counter.
// One access in flight at a time; completion is a single-cycle cpu_ready_o pulse.
module mio_bus_ctrl #(
    parameter int unsigned RAM_LAT = 2,   // ram_en -> ram_rdata valid, 1..15
    parameter int unsigned RAM_AW  = 10   // RAM word-address width
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic [15:0]       sw_in_i,
    output logic [15:0]       led_out_o,
    output logic [31:0]       cnt_out_o,
    output logic              cnt_irq_o
);

    localparam logic [31:0] LedAddr = 32'hE000_0000;
    localparam logic [31:0] SwAddr  = 32'hF000_0000;
    localparam logic [31:0] CntAddr = 32'hF000_0004;
    localparam logic [3:0]  RamLat  = 4'(RAM_LAT);

    typedef enum logic [1:0] {StIdle, StRamWait, StIo, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:2]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wait_q, wait_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               ram_en_q, ram_en_d;
    logic               ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]  ram_addr_q, ram_addr_d;
    logic [31:0]        ram_wdata_q, ram_wdata_d;
    logic [15:0]        led_q, led_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic [31:0]        io_rdata;

    // Byte-lane bits carry no meaning on this word-only bus.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    // Peripheral read mux on the latched word address; unmapped reads return 0.
    always_comb begin
        io_rdata = 32'h0;
        if ({addr_q, 2'b00} == LedAddr) begin
            io_rdata = {16'h0, led_q};
        end else if ({addr_q, 2'b00} == SwAddr) begin
            io_rdata = {16'h0, sw_in_i};
        end else if ({addr_q, 2'b00} == CntAddr) begin
            io_rdata = cnt_q;
        end
    end

    // Next-state logic for the access FSM, RAM strobes and peripherals.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        led_d       = led_q;
        cnt_d       = cnt_q;
        irq_d       = irq_q;

        // Free-running down-counter; the 1->0 step arms the sticky flag.
        if (cnt_q != 32'h0) begin
            cnt_d = cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
                irq_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cpu_req_i) begin
                    addr_d  = cpu_addr_i[31:2];
                    we_d    = cpu_we_i;
                    wdata_d = cpu_wdata_i;
                    if (cpu_addr_i[31:28] == 4'h0) begin
                        state_d     = StRamWait;
                        ram_en_d    = 1'b1;
                        ram_we_d    = cpu_we_i;
                        ram_addr_d  = cpu_addr_i[RAM_AW+1:2];
                        ram_wdata_d = cpu_wdata_i;
                        wait_d      = RamLat;
                    end else begin
                        state_d = StIo;
                    end
                end
            end
            StRamWait: begin
                // Counter hits zero exactly in the cycle the RAM data is valid.
                if (wait_q == 4'd0) begin
                    if (!we_q) begin
                        cpu_rdata_d = ram_rdata_i;
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StIo: begin
                if (we_q) begin
                    if ({addr_q, 2'b00} == LedAddr) begin
                        led_d = wdata_q[15:0];
                    end else if ({addr_q, 2'b00} == CntAddr) begin
                        // CPU write overrides same-cycle decrement/expiry.
                        cnt_d = wdata_q;
                        irq_d = 1'b0;
                    end
                end else begin
                    cpu_rdata_d = io_rdata;
                end
                cpu_ready_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any access.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            wait_q      <= 4'd0;
            cpu_rdata_q <= 32'h0;
            cpu_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            led_q       <= 16'h0;
            cnt_q       <= 32'h0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            led_q       <= led_d;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign led_out_o   = led_q;
    assign cnt_out_o   = cnt_q;
    assign cnt_irq_o   = irq_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: RAM model with fixed read latency,
// scoreboard of expected read data popped on each cpu_ready pulse.
module tb_mio_bus_ctrl;

    localparam int unsigned RamLat = 2;
    localparam int unsigned RamAw  = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_req;
    logic             cpu_we;
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_ready;
    logic             ram_en;
    logic             ram_we;
    logic [RamAw-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [15:0]      sw_in;
    logic [15:0]      led_out;
    logic [31:0]      cnt_out;
    logic             cnt_irq;

    mio_bus_ctrl #(
        .RAM_LAT (RamLat),
        .RAM_AW  (RamAw)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .sw_in_i     (sw_in),
        .led_out_o   (led_out),
        .cnt_out_o   (cnt_out),
        .cnt_irq_o   (cnt_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: data valid RamLat cycles after the ram_en cycle.
    logic [31:0] mem [1 << RamAw];
    logic [31:0] pipe [RamLat];
    initial for (int i = 0; i < (1 << RamAw); i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < RamLat; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[RamLat-1];

    // Strobe monitor.
    int               ram_en_cnt = 0;
    logic             last_ram_we;
    logic [RamAw-1:0] last_ram_addr;
    logic [31:0]      last_ram_wdata;
    always @(negedge clk) begin
        if (ram_en) begin
            ram_en_cnt++;
            last_ram_we    = ram_we;
            last_ram_addr  = ram_addr;
            last_ram_wdata = ram_wdata;
        end
    end

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU access; returns at the negedge of the cpu_ready cycle.
    task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rd_exp, input int pulses);
        int t0, p0;
        bit got;
        logic [31:0] e;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        t0 = cyc; p0 = ram_en_cnt;
        exp_q.push_back(we ? last_rd : rd_exp);
        if (!we) last_rd = rd_exp;
        @(negedge clk);
        cpu_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (cpu_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq({tag, "_ready_seen"}, 32'(got), 32'd1);
        e = exp_q.pop_front();
        if (got) begin
            check_eq({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
            check_eq({tag, "_rdata"}, cpu_rdata, e);
        end
        check_eq({tag, "_ram_pulses"}, 32'(ram_en_cnt - p0), 32'(pulses));
    endtask

    initial begin
        int t0, p0, nready;
        logic [31:0] e;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        sw_in = 16'hBEEF;
        repeat (3) @(negedge clk);
        check_eq("rst_rdata", cpu_rdata, 32'h0);
        check_eq("rst_ready", 32'(cpu_ready), 32'd0);
        check_eq("rst_ram_en", 32'(ram_en), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_led", 32'(led_out), 32'd0);
        check_eq("rst_cnt", cnt_out, 32'h0);
        check_eq("rst_irq", 32'(cnt_irq), 32'd0);
        reset = 1'b0;

        // RAM write then read.
        run_access("ram_wr", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, RamLat + 2, 32'h0, 1);
        check_eq("ram_wr_addr", 32'(last_ram_addr), 32'd4);
        check_eq("ram_wr_we", 32'(last_ram_we), 32'd1);
        check_eq("ram_wr_wdata", last_ram_wdata, 32'hDEAD_BEEF);
        run_access("ram_rd", 1'b0, 32'h0000_0010, 32'h0, RamLat + 2, 32'hDEAD_BEEF, 1);
        check_eq("ram_rd_we", 32'(last_ram_we), 32'd0);
        run_access("ram_wr_top", 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, RamLat + 2, 32'h0, 1);
        check_eq("ram_top_addr", 32'(last_ram_addr), 32'h3FF);
        run_access("ram_rd_top", 1'b0, 32'h0000_0FFC, 32'h0, RamLat + 2, 32'h0BAD_F00D, 1);

        // LED register.
        run_access("led_wr", 1'b1, 32'hE000_0000, 32'h1234_A5A5, 2, 32'h0, 0);
        check_eq("led_val", 32'(led_out), 32'h0000_A5A5);
        run_access("led_rd", 1'b0, 32'hE000_0000, 32'h0, 2, 32'h0000_A5A5, 0);

        // Switches.
        run_access("sw_rd", 1'b0, 32'hF000_0000, 32'h0, 2, 32'h0000_BEEF, 0);
        run_access("sw_wr", 1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 2, 32'h0, 0);
        check_eq("sw_wr_led", 32'(led_out), 32'h0000_A5A5);
        check_eq("sw_wr_cnt", cnt_out, 32'h0);

        // Unmapped read with cpu_req held through DONE: exactly one extra access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8000_0000;
        t0 = cyc; p0 = ram_en_cnt; nready = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); last_rd = 32'h0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            if (cpu_ready) begin
                nready++;
                check_eq("held_latency", 32'(cyc - t0), (nready == 1) ? 32'd2 : 32'd5);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check_eq("held_rdata", cpu_rdata, e);
            end
            if (k == 4) cpu_req = 1'b0;
        end
        check_eq("held_count", 32'(nready), 32'd2);
        check_eq("held_ram_pulses", 32'(ram_en_cnt - p0), 32'd0);
        exp_q.delete();

        // Counter countdown and sticky flag.
        run_access("cnt_wr3", 1'b1, 32'hF000_0004, 32'd3, 2, 32'h0, 0);
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("cnt_seq%0d", k), cnt_out, (k < 3) ? 32'(3 - k) : 32'd0);
            check_eq($sformatf("irq_seq%0d", k), 32'(cnt_irq), (k < 3) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        run_access("cnt_rd", 1'b0, 32'hF000_0004, 32'h0, 2, 32'h0, 0);
        run_access("cnt_wr5", 1'b1, 32'hF000_0004, 32'd5, 2, 32'h0, 0);
        check_eq("cnt5_val", cnt_out, 32'd5);
        check_eq("cnt5_irq", 32'(cnt_irq), 32'd0);
        repeat (8) @(negedge clk);
        check_eq("cnt5_expired_irq", 32'(cnt_irq), 32'd1);

        // Reset while a RAM read is waiting.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        p0 = ram_en_cnt;
        @(negedge clk);
        cpu_req = 1'b0;
        check_eq("abort_t1_ram_en", 32'(ram_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_ready", 32'(cpu_ready), 32'd0);
        check_eq("abort_ram_en", 32'(ram_en), 32'd0);
        check_eq("abort_rdata", cpu_rdata, 32'h0);
        check_eq("abort_led", 32'(led_out), 32'd0);
        check_eq("abort_cnt", cnt_out, 32'h0);
        check_eq("abort_irq", 32'(cnt_irq), 32'd0);
        check_eq("abort_ram_addr", 32'(ram_addr), 32'd0);
        nready = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ready) nready++;
        end
        check_eq("abort_no_ready", 32'(nready), 32'd0);
        check_eq("abort_ram_pulses", 32'(ram_en_cnt - p0), 32'd1);
        last_rd = 32'h0;
        run_access("post_abort_rd", 1'b0, 32'h0000_0010, 32'h0, RamLat + 2, 32'hDEAD_BEEF, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Memory/IO bus controller directly downstream of the multicycle CPU's memory port. It consumes the CPU's address, write-data and write-enable. It returns read data and a one-cycle ready handshake. It decodes each access to an external synchronous RAM or to three internal peripherals: LED register, switch input, and a down-counter with sticky interrupt flag.

Parameters:
RAM_LAT, 2, cycles from ram_en high to ram_rdata valid (legal range 1..15)
RAM_AW, 10, RAM word-address width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  access request, sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read (CPU mem_w)
cpu_addr  in  32  byte address (CPU Addr_out), bits [1:0] ignored
cpu_wdata  in  32  write data (CPU Data_out)
cpu_rdata  out  32  read data (CPU Data_in)
cpu_ready  out  1  one-cycle completion pulse (CPU MIO_ready)
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  RAM_AW  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data
sw_in  in  16  switch inputs
led_out  out  16  LED register
cnt_out  out  32  counter value
cnt_irq  out  1  sticky counter-expired flag

Behaviour:
- Reset: state IDLE, cpu_rdata=0, cpu_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, led_out=0, cnt_out=0, cnt_irq=0, wait counter=0.
- Reset during any state aborts the access. Next cycle is IDLE, no cpu_ready pulse, no further RAM strobe.
- Address map:
  - addr[31:28]=0x0: RAM, word index addr[RAM_AW+1:2].
  - 0xE000_0000: LED. Write loads wdata[15:0]. Read returns {16'h0, led_out}.
  - 0xF000_0000: switches. Read returns {16'h0, sw_in}. Write ignored.
  - 0xF000_0004: counter. Write loads the counter. Read returns cnt_out.
  - Anything else: read returns 0, write ignored, access still completes.
- Registered outputs: all outputs.
- FSM states: IDLE, RAM_WAIT, IO, DONE.
- IDLE:
  - If cpu_req=1 in cycle T0, latch addr, we and wdata.
  - RAM hit: go to RAM_WAIT. ram_en=1 and ram_we=cpu_we for exactly cycle T1, with ram_addr and ram_wdata driven from the latched values. Load wait counter with RAM_LAT.
  - Non-RAM: go to IO.
- RAM_WAIT:
  - Wait counter decrements each cycle.
  - At cycle T1+RAM_LAT, capture ram_rdata into cpu_rdata (reads only) and go to DONE.
  - ram_en=0 after T1.
- IO:
  - Perform the peripheral read or write in cycle T1.
  - Read data is registered into cpu_rdata.
  - Go to DONE.
- DONE:
  - cpu_ready=1 for this single cycle.
  - cpu_req is ignored in DONE. Next state is IDLE unconditionally.
  - The CPU must drop cpu_req on ready; a still-high cpu_req in the following IDLE starts a new access.
- Latency, cpu_req at T0 (read and write identical):
  - RAM: cpu_ready in cycle T0+RAM_LAT+2.
  - IO or unmapped: cpu_ready in cycle T0+2.
- cpu_rdata on writes: unchanged by writes. Holds its value until the next read capture.
- Counter:
  - 32-bit, decrements by 1 every cycle while nonzero; holds at 0.
  - On a 1→0 transition cnt_irq sets and stays set.
  - A CPU write to the counter loads cpu_wdata and clears cnt_irq. The new value appears on cnt_out the cycle after IO.
  - A CPU write in the same cycle as a decrement or expiry: write wins and cnt_irq is cleared.
  - Writing 0 clears cnt_irq and does not set it.
- Simultaneous events: only one access is in flight at a time. cpu_req outside IDLE is never queued.

Test Plan:
- RAM_LAT=2. Write 0xDEADBEEF to 0x0000_0010, req at T0 → ram_en=ram_we=1 at T1 only, ram_addr=4, cpu_ready at T0+4. Read the same address → cpu_rdata=0xDEADBEEF with cpu_ready at T0+4, ram_we=0.
- Write 0x1234_A5A5 to 0xE000_0000 → cpu_ready at T0+2, led_out=0xA5A5. Read back → cpu_rdata=0x0000_A5A5. ram_en stays 0 throughout.
- sw_in=0xBEEF, read 0xF000_0000 → cpu_rdata=0x0000_BEEF. Write 0xFFFF_FFFF to 0xF000_0000 → led_out and cnt_out unchanged, cpu_ready still pulses.
- Write 3 to 0xF000_0004 → cnt_out 3,2,1,0 on successive cycles, then holds 0. cnt_irq rises with cnt_out=0 and stays high. Write 5 → cnt_irq=0, cnt_out=5.
- Read 0x8000_0000 → cpu_rdata=0, cpu_ready at T0+2, no ram_en. cpu_req held high through DONE → exactly one new access starts in the next IDLE.
- Assert reset for 1 cycle during RAM_WAIT (RAM read in flight) → next cycle IDLE, all outputs at reset values, no cpu_ready pulse. The following access completes normally.
